// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Holds the FSM state encoding, the HALT opcode and the opcode field bounds.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } seq_state_e;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 10;
    localparam logic [5:0] HALT_OPCODE = 6'h3F;

    // True when the opcode field of an instruction is the HALT opcode.
    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[OPC_MSB:OPC_LSB] == HALT_OPCODE);
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Instruction buffer for the sequencer: circular FIFO with pointers that
// wrap modulo DEPTH and an occupancy counter one bit wider than the
// pointers, so that full and empty can be told apart. flush empties it.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == FULL_CNT);
    assign empty  = (count_r == (PTR_W + 1)'(0));
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign dout   = mem_r[rd_ptr_r];

    // Write the accepted instruction into the slot at the tail.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Advance pointers and occupancy; a push and a pop together cancel out.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers instructions from a producer and, once
// started, issues them one per cycle to the CPU datapath until a HALT
// opcode is popped. HALT is consumed silently; a start in HALTED flushes
// the buffer and returns to IDLE.
// Optional feature: define SEQ_ISSUE_COUNT_EN to build the saturating
// issue counter; otherwise issue_count is tied to zero.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in_instr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    output logic [15:0]      instruction_out,
    output logic             instruction_valid,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] issue_count
);

    seq_state_e  state_r;
    seq_state_e  state_next_s;
    logic        flush_s;
    logic        push_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic [15:0] head_s;
    logic        head_is_halt_s;
    logic        issue_s;
    logic [15:0] instr_out_r;
    logic        instr_valid_r;

    assign in_ready       = ~full_s & (state_r != HALTED);
    assign push_s         = in_valid & in_ready;
    assign pop_s          = (state_r == RUN) & ~empty_s;
    assign head_is_halt_s = is_halt(head_s);
    assign issue_s        = pop_s & ~head_is_halt_s;
    assign busy           = (state_r == RUN);
    assign halted         = (state_r == HALTED);

    assign instruction_out   = instr_out_r;
    assign instruction_valid = instr_valid_r;

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (push_s),
        .pop   (pop_s),
        .din   (in_instr),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; leaving HALTED also flushes the buffer.
    always_comb begin
        state_next_s = state_r;
        flush_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (pop_s && head_is_halt_s) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALTED: begin
                if (start) begin
                    state_next_s = IDLE;
                    flush_s      = 1'b1;
                end else begin
                    state_next_s = HALTED;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Issue register: a popped non-HALT instruction appears for one cycle;
    // the data holds its last value otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_out_r   <= 16'h0000;
            instr_valid_r <= 1'b0;
        end else if (issue_s) begin
            instr_out_r   <= head_s;
            instr_valid_r <= 1'b1;
        end else begin
            instr_out_r   <= instr_out_r;
            instr_valid_r <= 1'b0;
        end
    end

`ifdef SEQ_ISSUE_COUNT_EN
    logic [CNT_W-1:0] issue_count_r;

    // Count issued instructions, saturating at the all-ones value.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_count_r <= '0;
        end else if (issue_s && (issue_count_r != {CNT_W{1'b1}})) begin
            issue_count_r <= issue_count_r + CNT_W'(1);
        end else begin
            issue_count_r <= issue_count_r;
        end
    end

    assign issue_count = issue_count_r;
`else
    assign issue_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (DEPTH=4, CNT_W=8).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic [15:0] instruction_out;
    logic        instruction_valid;
    logic        busy;
    logic        halted;
    logic [7:0]  issue_count;

    int checks = 0;
    int errors = 0;
    int total  = 0;

    instr_sequencer #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_instr          (in_instr),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .start             (start),
        .instruction_out   (instruction_out),
        .instruction_valid (instruction_valid),
        .busy              (busy),
        .halted            (halted),
        .issue_count       (issue_count)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef SEQ_ISSUE_COUNT_EN
        return (total > 255) ? 32'd255 : 32'(total);
`else
        return 32'd0;
`endif
    endfunction

    task automatic push1(input logic [15:0] v);
        in_instr = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out"},   32'(instruction_out), 32'h0);
        chk({tag, "_valid"}, 32'(instruction_valid), 32'h0);
        chk({tag, "_cnt"},   32'(issue_count), 32'h0);
        chk({tag, "_ready"}, 32'(in_ready), 32'h1);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_halt"},  32'(halted), 32'h0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Three pushes in IDLE, then start: three back-to-back issues.
        push1(16'h0401);
        chk("idle_no_issue", 32'(instruction_valid), 32'h0);
        push1(16'h0802);
        push1(16'h0C03);
        chk("idle_busy", 32'(busy), 32'h0);
        pulse_start();
        chk("run_busy", 32'(busy), 32'h1);
        chk("run_first_lat", 32'(instruction_valid), 32'h0);
        step();
        chk("seq_v0", 32'(instruction_valid), 32'h1);
        chk("seq_d0", 32'(instruction_out), 32'h0401);
        step();
        chk("seq_v1", 32'(instruction_valid), 32'h1);
        chk("seq_d1", 32'(instruction_out), 32'h0802);
        step();
        chk("seq_v2", 32'(instruction_valid), 32'h1);
        chk("seq_d2", 32'(instruction_out), 32'h0C03);
        total = 3;
        step();
        chk("seq_end_valid", 32'(instruction_valid), 32'h0);
        chk("seq_hold_out", 32'(instruction_out), 32'h0C03);
        chk("seq_cnt", 32'(issue_count), exp_cnt());

        // HALT in the middle of a RUN stream.
        in_valid = 1'b1;
        in_instr = 16'h0401;
        step();
        chk("halt_lat", 32'(instruction_valid), 32'h0);
        in_instr = 16'hFC00;
        step();
        chk("halt_pre_v", 32'(instruction_valid), 32'h1);
        chk("halt_pre_d", 32'(instruction_out), 32'h0401);
        total = 4;
        in_instr = 16'h0802;
        step();
        in_valid = 1'b0;
        chk("halt_valid", 32'(instruction_valid), 32'h0);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_busy", 32'(busy), 32'h0);
        chk("halt_ready", 32'(in_ready), 32'h0);
        chk("halt_hold_out", 32'(instruction_out), 32'h0401);
        step();
        chk("halt_stay_v", 32'(instruction_valid), 32'h0);
        chk("halt_cnt", 32'(issue_count), exp_cnt());
        pulse_start();
        chk("unhalt_flag", 32'(halted), 32'h0);
        chk("unhalt_busy", 32'(busy), 32'h0);
        chk("unhalt_ready", 32'(in_ready), 32'h1);

        // Fill a flushed buffer: exactly 4 accepted, 5th held until a pop.
        for (int i = 0; i < 4; i++) begin
            push1(16'h1001 + 16'(i));
            chk("fill_ready", 32'(in_ready), (i < 3) ? 32'h1 : 32'h0);
        end
        in_valid = 1'b1;
        in_instr = 16'h1005;
        step();
        chk("full_hold_ready", 32'(in_ready), 32'h0);
        chk("full_hold_valid", 32'(instruction_valid), 32'h0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("full_run_ready", 32'(in_ready), 32'h0);
        step();
        chk("full_d0", 32'(instruction_out), 32'h1001);
        chk("full_pop_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("full_d1", 32'(instruction_out), 32'h1002);
        step();
        chk("full_d2", 32'(instruction_out), 32'h1003);
        step();
        chk("full_d3", 32'(instruction_out), 32'h1004);
        step();
        chk("full_d4_v", 32'(instruction_valid), 32'h1);
        chk("full_d4", 32'(instruction_out), 32'h1005);
        total = 9;
        step();
        chk("full_done_v", 32'(instruction_valid), 32'h0);
        chk("full_cnt", 32'(issue_count), exp_cnt());

        // Continuous streaming in RUN across several pointer wraps.
        for (int k = 0; k < 12; k++) begin
            in_instr = 16'h2000 + 16'(k);
            in_valid = 1'b1;
            step();
            chk("stream_ready", 32'(in_ready), 32'h1);
            if (k > 0) begin
                chk("stream_v", 32'(instruction_valid), 32'h1);
                chk("stream_d", 32'(instruction_out), 32'(16'h2000 + 16'(k - 1)));
            end
        end
        in_valid = 1'b0;
        step();
        chk("stream_last", 32'(instruction_out), 32'h200B);
        total = 21;
        step();
        chk("stream_end_v", 32'(instruction_valid), 32'h0);
        chk("stream_cnt", 32'(issue_count), exp_cnt());

        // Reset in the middle of a RUN with three instructions buffered.
        push1(16'hFC00);
        step();
        chk("rst_prep_halt", 32'(halted), 32'h1);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            push1(16'h3001 + 16'(i));
        end
        pulse_start();
        step();
        chk("rst_pre_d", 32'(instruction_out), 32'h3001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total = 0;
        chk_reset_outputs("midrst");
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_stale", 32'(instruction_valid), 32'h0);
        end

        // Long stream to exercise counter saturation.
        for (int k = 0; k < 260; k++) begin
            in_instr = 16'h0400 + 16'(k);
            in_valid = 1'b1;
            step();
            total = k;
            if (k > 0) begin
                chk("long_d", 32'(instruction_out), 32'(16'h0400 + 16'(k - 1)));
            end
            if (k == 200) begin
                chk("long_cnt_mid", 32'(issue_count), exp_cnt());
            end
        end
        in_valid = 1'b0;
        step();
        total = 260;
        chk("long_last", 32'(instruction_out), 32'h0503);
        chk("long_cnt_sat", 32'(issue_count), exp_cnt());
        step();
        chk("long_cnt_hold", 32'(issue_count), exp_cnt());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
